sha256_nonce_sweep_ctrl: RTL and testbench
==========================================

Name: sha256_nonce_sweep_ctrl

Overview:
Sequences one external sha256_doublehash_core through a nonce sweep for Bitcoin-style mining. For each nonce it:
- inserts the nonce into an 80-byte header template;
- restarts the core and waits the core's fixed latency;
- compares the double-hash against a target.
It stops on the first hit, on reaching nonce_end, or on abort, and reports the result through a start/done handshake.

Parameters:
CORE_RST_CYCLES, 2, cycles core_reset is held high before each hash (min 1)
HASH_LATENCY, 220, cycles from core_reset deassertion until core_digest is valid and stable
NONCE_W, 32, nonce and hash-counter width (fixed by header format)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  terminate sweep; honoured in any non-IDLE state
header_template  in  640  header, serialized byte order; bits [31:0] ignored
nonce_start  in  32  first nonce
nonce_end  in  32  last nonce, inclusive
target  in  256  hit if hash value <= target
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when sweep ends
found  out  1  last sweep hit; held until next accepted start
found_nonce  out  32  nonce of hit; held
found_digest  out  256  raw core digest of hit; held
hash_count  out  32  hashes completed in current/last sweep
core_reset  out  1  drives core reset
core_header  out  640  drives core blockHeader
core_digest  in  256  core digest output

Behaviour:
- Reset: state=IDLE, busy=0, done=0, found=0, found_nonce=0, found_digest=0, hash_count=0, core_reset=1, core_header=0.
- Reset is honoured mid-sweep with the same values; no done pulse.
- Nonce insertion: core_header = {template[639:32], bswap32(nonce)}. Example: nonce 0x9546A142 gives bytes 42 a1 46 95.
- Hash value = bswap256(core_digest), compared unsigned against target.
- IDLE: core_reset=1. On start:
  - latch template, target, nonce_end;
  - nonce <= nonce_start;
  - clear found, found_nonce, found_digest, hash_count;
  - busy <= 1;
  - go to LOAD.
- LOAD: core_reset=1 for CORE_RST_CYCLES cycles, core_header valid; then HASH.
- HASH: core_reset=0; down-counter runs HASH_LATENCY cycles; then CHECK.
- CHECK (1 cycle), sample core_digest, hash_count+1, then:
  - if hash <= target: found=1, latch nonce and digest, go DONE;
  - else if nonce==nonce_end: go DONE with found=0;
  - else nonce <= nonce+1 (mod 2^32, so start>end wraps through 0xFFFFFFFF→0), go LOAD.
- DONE (1 cycle): done=1, busy=0, core_reset=1; next state IDLE.
- Latency per nonce: CORE_RST_CYCLES+HASH_LATENCY+1 cycles.
- done asserts N·(CORE_RST_CYCLES+HASH_LATENCY+1)+1 cycles after the start-accepting edge, where N = hashes completed.
- abort in LOAD/HASH/CHECK: next state DONE, found=0, no hash_count increment. abort beats a same-cycle hit in CHECK.
- abort in IDLE or DONE is ignored.
- start while busy or in DONE is ignored.
- nonce_start==nonce_end: exactly one hash.

Decomposition:
- Package sha256_miner_pkg:
  - state enum {IDLE, LOAD, HASH, CHECK, DONE};
  - bswap32 and bswap256 functions;
  - constants HEADER_W=640, DIGEST_W=256, NONCE_LSB=0.
- No sub-module inside the controller. The core is instantiated beside it at the top level (sha256_miner_top).

Test Plan:
1. Single-nonce hit: template = Bitcoin block 125552 header, nonce_start=nonce_end=0x9546A142, target=256'h0000000000000000FFFF…FF (16 zero nibbles, then 48 F nibbles).
   -> found=1, found_nonce=0x9546A142, found_digest=256'h1dbd981fe6985776b644b173a4d0385ddc1aa2a829688d1e0000000000000000, hash_count=1, done exactly 224 cycles after start.
2. Range hit: same template, range 0x9546A140..0x9546A143, same target.
   -> found_nonce=0x9546A142, hash_count=3, core_header[31:0] sequence 40a14695, 41a14695, 42a14695; done at cycle 3·223+1=670.
3. Miss: range 0x9546A142..0x9546A142, target=0.
   -> found=0, hash_count=1, done at 224, busy low afterwards.
4. Wrap: range 0xFFFFFFFF..0x00000000, target=0.
   -> hash_count=2, core_header[31:0] = ffffffff then 00000000, found=0.
5. Abort: assert abort for 1 cycle at cycle 100 of a 4-nonce sweep.
   -> done one cycle later, found=0, hash_count=0, core_reset=1. A start during the sweep is ignored.
6. Reset mid-HASH.
   -> all outputs at reset values next cycle, no done. A following start runs scenario 1 correctly.

Source files
------------

// File: rtl/sha256_miner_pkg.sv
// Shared types, widths and byte-order helpers for the nonce sweep controller.
package sha256_miner_pkg;

    localparam int unsigned HEADER_W      = 640;
    localparam int unsigned DIGEST_W      = 256;
    localparam int unsigned NONCE_LSB     = 0;
    localparam int unsigned NONCE_FIELD_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HASH  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [DIGEST_W-1:0] bswap256(input logic [DIGEST_W-1:0] x);
        logic [DIGEST_W-1:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = x[8*(31-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_nonce_sweep_ctrl.sv
// Walks a nonce range through one external double-SHA256 core and reports
// the first nonce whose byte-reversed digest is at or below the target.
module sha256_nonce_sweep_ctrl
    import sha256_miner_pkg::*;
#(
    parameter int unsigned CORE_RST_CYCLES = 2,
    parameter int unsigned HASH_LATENCY    = 220,
    parameter int unsigned NONCE_W         = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [HEADER_W-1:0] header_template,
    input  logic [NONCE_W-1:0]  nonce_start,
    input  logic [NONCE_W-1:0]  nonce_end,
    input  logic [DIGEST_W-1:0] target,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [NONCE_W-1:0]  found_nonce,
    output logic [DIGEST_W-1:0] found_digest,
    output logic [NONCE_W-1:0]  hash_count,
    output logic                core_reset,
    output logic [HEADER_W-1:0] core_header,
    input  logic [DIGEST_W-1:0] core_digest
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TMPL_LSB = NONCE_LSB + NONCE_FIELD_W;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NONCE_W-1:0]    nonce_q, nonce_d;
    logic [NONCE_W-1:0]    nonce_end_q, nonce_end_d;
    logic [DIGEST_W-1:0]   target_q, target_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  found_q, found_d;
    logic [NONCE_W-1:0]    found_nonce_q, found_nonce_d;
    logic [DIGEST_W-1:0]   found_digest_q, found_digest_d;
    logic [NONCE_W-1:0]    hash_count_q, hash_count_d;
    logic                  core_reset_q, core_reset_d;
    logic [HEADER_W-1:0]   core_header_q, core_header_d;
    logic [DIGEST_W-1:0]   hash_c;
    logic                  tmpl_unused_c;

    // The template's nonce field is always overwritten, so its low bits are dead.
    assign tmpl_unused_c = ^header_template[TMPL_LSB-1:0];
    assign hash_c        = bswap256(core_digest);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        nonce_d        = nonce_q;
        nonce_end_d    = nonce_end_q;
        target_d       = target_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        found_d        = found_q;
        found_nonce_d  = found_nonce_q;
        found_digest_d = found_digest_q;
        hash_count_d   = hash_count_q;
        core_header_d  = core_header_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    nonce_d        = nonce_start;
                    nonce_end_d    = nonce_end;
                    target_d       = target;
                    busy_d         = 1'b1;
                    found_d        = 1'b0;
                    found_nonce_d  = '0;
                    found_digest_d = '0;
                    hash_count_d   = '0;
                    cnt_d          = CNT_W'(CORE_RST_CYCLES - 1);
                    core_header_d  = {header_template[HEADER_W-1:TMPL_LSB], bswap32(nonce_start)};
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(HASH_LATENCY - 1);
                    state_d = HASH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HASH: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHECK: begin
                hash_count_d = hash_count_q + NONCE_W'(1);
                if (hash_c <= target_q) begin
                    found_d        = 1'b1;
                    found_nonce_d  = nonce_q;
                    found_digest_d = core_digest;
                    state_d        = DONE;
                end else if (nonce_q == nonce_end_q) begin
                    state_d = DONE;
                end else begin
                    nonce_d       = nonce_q + NONCE_W'(1);
                    core_header_d = {core_header_q[HEADER_W-1:TMPL_LSB], bswap32(nonce_d)};
                    cnt_d         = CNT_W'(CORE_RST_CYCLES - 1);
                    state_d       = LOAD;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort discards whatever the active state decided, including a hit.
        if (abort && (state_q inside {LOAD, HASH, CHECK})) begin
            state_d        = DONE;
            nonce_d        = nonce_q;
            found_d        = 1'b0;
            found_nonce_d  = found_nonce_q;
            found_digest_d = found_digest_q;
            hash_count_d   = hash_count_q;
            core_header_d  = core_header_q;
        end

        core_reset_d = (state_d != HASH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            nonce_q        <= '0;
            nonce_end_q    <= '0;
            target_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            found_q        <= 1'b0;
            found_nonce_q  <= '0;
            found_digest_q <= '0;
            hash_count_q   <= '0;
            core_reset_q   <= 1'b1;
            core_header_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            nonce_q        <= nonce_d;
            nonce_end_q    <= nonce_end_d;
            target_q       <= target_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            found_q        <= found_d;
            found_nonce_q  <= found_nonce_d;
            found_digest_q <= found_digest_d;
            hash_count_q   <= hash_count_d;
            core_reset_q   <= core_reset_d;
            core_header_q  <= core_header_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign found        = found_q;
    assign found_nonce  = found_nonce_q;
    assign found_digest = found_digest_q;
    assign hash_count   = hash_count_q;
    assign core_reset   = core_reset_q;
    assign core_header  = core_header_q;

endmodule

// File: tb/tb_sha256_nonce_sweep_ctrl.sv
// Directed bench for the nonce sweep controller with a behavioural stand-in
// for the double-hash core that only knows the block 125552 winning nonce.
module tb_sha256_nonce_sweep_ctrl;

    localparam int unsigned LAT   = 220;
    localparam int unsigned LIMIT = 3000;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [639:0] header_template;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [255:0] target;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  found_nonce;
    logic [255:0] found_digest;
    logic [31:0]  hash_count;
    logic         core_reset;
    logic [639:0] core_header;
    logic [255:0] core_digest;

    logic [639:0] blk_hdr = 640'h0100000081cd02ab7e569e8bcd9317e2fe99f2de44d49ab2b8851ba4a308000000000000e320b6c2fffc8d750423db8b1eb942ae710e951ed797f7affc8892b0f1fc122bc7f5d74df2b9441a42a14695;
    logic [255:0] hit_digest = 256'h1dbd981fe6985776b644b173a4d0385ddc1aa2a829688d1e0000000000000000;
    logic [255:0] easy_target = {64'h0, {192{1'b1}}};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sha256_nonce_sweep_ctrl #(
        .CORE_RST_CYCLES(2),
        .HASH_LATENCY   (LAT),
        .NONCE_W        (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .header_template(header_template),
        .nonce_start    (nonce_start),
        .nonce_end      (nonce_end),
        .target         (target),
        .busy           (busy),
        .done           (done),
        .found          (found),
        .found_nonce    (found_nonce),
        .found_digest   (found_digest),
        .hash_count     (hash_count),
        .core_reset     (core_reset),
        .core_header    (core_header),
        .core_digest    (core_digest)
    );

    // Core stand-in: digest reads zero (a false hit) until the latency has elapsed.
    int lat_cnt = 0;
    always @(posedge clk) begin
        if (core_reset) begin
            lat_cnt     <= 0;
            core_digest <= '0;
        end else begin
            if (lat_cnt == LAT - 1)
                core_digest <= (core_header == blk_hdr) ? hit_digest : {256{1'b1}};
            if (lat_cnt < LAT)
                lat_cnt <= lat_cnt + 1;
        end
    end

    // Nonce field seen by the core at each hash launch.
    logic [31:0] hdr_log [0:63];
    int          hdr_n = 0;
    logic        prev_rst = 1'b1;
    always @(negedge clk) begin
        if (prev_rst && !core_reset && hdr_n < 64) begin
            hdr_log[hdr_n] <= core_header[31:0];
            hdr_n          <= hdr_n + 1;
        end
        prev_rst <= core_reset;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch a sweep and return cycles from the accepting edge to done (-1 on timeout).
    task automatic run_sweep(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tgt,
                             input int abort_cyc, input int stray_cyc, output int lat);
        int cyc;
        @(negedge clk);
        nonce_start = ns;
        nonce_end   = ne;
        target      = tgt;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 256'(busy), 256'(1));
        cyc = 0;
        lat = -1;
        while (cyc < LIMIT) begin
            abort = (cyc == abort_cyc - 1);
            start = (cyc == stray_cyc);
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) begin
                lat = cyc;
                break;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        if (lat < 0) check("done_timeout", 256'(0), 256'(1));
    endtask

    task automatic done_is_pulse(input string tag);
        @(negedge clk);
        check(tag, 256'(done), 256'(0));
    endtask

    initial begin
        int lat;
        int base;
        int done_seen;

        reset           = 1'b1;
        start           = 1'b0;
        abort           = 1'b0;
        header_template = {blk_hdr[639:32], 32'hdeadbeef};
        nonce_start     = '0;
        nonce_end       = '0;
        target          = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_found", 256'(found), 256'(0));
        check("rst_hash_count", 256'(hash_count), 256'(0));
        check("rst_core_reset", 256'(core_reset), 256'(1));
        check("rst_core_header_lo", 256'(core_header[255:0]), 256'(0));
        reset = 1'b0;

        // Single-nonce hit
        base = hdr_n;
        run_sweep(32'h9546A142, 32'h9546A142, easy_target, -10, -10, lat);
        check("t1_latency", 256'(lat), 256'(224));
        check("t1_found", 256'(found), 256'(1));
        check("t1_found_nonce", 256'(found_nonce), 256'(32'h9546A142));
        check("t1_found_digest", found_digest, hit_digest);
        check("t1_hash_count", 256'(hash_count), 256'(1));
        check("t1_header_lo", 256'(hdr_log[base]), 256'(32'h42a14695));
        check("t1_busy_at_done", 256'(busy), 256'(0));
        done_is_pulse("t1_done_pulse");
        check("t1_found_held", 256'(found), 256'(1));

        // Range hit on the third nonce
        base = hdr_n;
        run_sweep(32'h9546A140, 32'h9546A143, easy_target, -10, -10, lat);
        check("t2_latency", 256'(lat), 256'(670));
        check("t2_found", 256'(found), 256'(1));
        check("t2_found_nonce", 256'(found_nonce), 256'(32'h9546A142));
        check("t2_hash_count", 256'(hash_count), 256'(3));
        check("t2_hdr0", 256'(hdr_log[base]), 256'(32'h40a14695));
        check("t2_hdr1", 256'(hdr_log[base+1]), 256'(32'h41a14695));
        check("t2_hdr2", 256'(hdr_log[base+2]), 256'(32'h42a14695));
        check("t2_hdr_count", 256'(hdr_n - base), 256'(3));

        // Miss against a zero target
        run_sweep(32'h9546A142, 32'h9546A142, 256'h0, -10, -10, lat);
        check("t3_latency", 256'(lat), 256'(224));
        check("t3_found", 256'(found), 256'(0));
        check("t3_found_nonce_cleared", 256'(found_nonce), 256'(0));
        check("t3_hash_count", 256'(hash_count), 256'(1));
        done_is_pulse("t3_done_pulse");
        check("t3_busy_after", 256'(busy), 256'(0));

        // Wrap through 0xFFFFFFFF
        base = hdr_n;
        run_sweep(32'hFFFFFFFF, 32'h00000000, 256'h0, -10, -10, lat);
        check("t4_latency", 256'(lat), 256'(447));
        check("t4_hash_count", 256'(hash_count), 256'(2));
        check("t4_hdr0", 256'(hdr_log[base]), 256'(32'hffffffff));
        check("t4_hdr1", 256'(hdr_log[base+1]), 256'(32'h00000000));
        check("t4_found", 256'(found), 256'(0));

        // Abort sampled at cycle 100 with a stray start at cycle 50
        base = hdr_n;
        run_sweep(32'h9546A140, 32'h9546A143, easy_target, 100, 50, lat);
        check("t5_latency", 256'(lat), 256'(101));
        check("t5_found", 256'(found), 256'(0));
        check("t5_hash_count", 256'(hash_count), 256'(0));
        check("t5_core_reset", 256'(core_reset), 256'(1));
        check("t5_busy", 256'(busy), 256'(0));
        check("t5_hdr_count", 256'(hdr_n - base), 256'(1));
        done_is_pulse("t5_done_pulse");

        // Reset in the middle of HASH
        @(negedge clk);
        nonce_start = 32'h9546A140;
        nonce_end   = 32'h9546A143;
        target      = easy_target;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", 256'(busy), 256'(0));
        check("t6_done", 256'(done), 256'(0));
        check("t6_found", 256'(found), 256'(0));
        check("t6_found_nonce", 256'(found_nonce), 256'(0));
        check("t6_found_digest", found_digest, 256'(0));
        check("t6_hash_count", 256'(hash_count), 256'(0));
        check("t6_core_reset", 256'(core_reset), 256'(1));
        check("t6_core_header_lo", 256'(core_header[255:0]), 256'(0));
        check("t6_core_header_hi", 256'(core_header[639:384]), 256'(0));
        done_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("t6_no_done", 256'(done_seen), 256'(0));

        base = hdr_n;
        run_sweep(32'h9546A142, 32'h9546A142, easy_target, -10, -10, lat);
        check("t6_rerun_latency", 256'(lat), 256'(224));
        check("t6_rerun_found", 256'(found), 256'(1));
        check("t6_rerun_nonce", 256'(found_nonce), 256'(32'h9546A142));
        check("t6_rerun_digest", found_digest, hit_digest);
        check("t6_rerun_hash_count", 256'(hash_count), 256'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
